// File: rtl/pc_stack_sequencer.sv
// pc_stack_sequencer: PC, fetch/execute phase, fetch register and call/return stack; STACK_CIRCULAR_EN makes overflow overwrite the oldest entry
module pc_stack_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int INSTR_W     = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               en,
  input  logic [INSTR_W-1:0]                 rom_data,
  input  logic                               jump,
  input  logic                               call,
  input  logic                               ret,
  input  logic [ADDR_W-1:0]                  target,
  output logic [ADDR_W-1:0]                  pc,
  output logic                               phase,
  output logic [INSTR_W-1:0]                 instr_q,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stack_err
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int PW = $clog2(STACK_DEPTH);
  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] stk [STACK_DEPTH];
  logic [PW-1:0] wp, wp_n, wp_inc, wp_dec;
  logic [ADDR_W-1:0] pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic [DW-1:0] depth_n;
  logic err_n, fetch, exec, do_ret, do_call, do_jump, pop, push, underflow, overflow;
  assign phase       = state == EXEC;
  assign stack_full  = depth == DW'(STACK_DEPTH);
  assign stack_empty = depth == '0;
  // wp is the next free slot; when full it also addresses the oldest entry
  assign wp_inc = (wp == PW'(STACK_DEPTH - 1)) ? '0 : wp + 1'b1;
  assign wp_dec = (wp == '0) ? PW'(STACK_DEPTH - 1) : wp - 1'b1;
  always_comb begin
    fetch     = en && state == FETCH;
    exec      = en && state == EXEC;
    do_ret    = exec && ret;
    do_call   = exec && call && !ret;
    do_jump   = exec && jump && !call && !ret;
    pop       = do_ret && !stack_empty;
    underflow = do_ret && stack_empty;
`ifdef STACK_CIRCULAR_EN
    push      = do_call;
    overflow  = 1'b0;
`else
    push      = do_call && !stack_full;
    overflow  = do_call && stack_full;
`endif
    state_n   = en ? (state == FETCH ? EXEC : FETCH) : state;
    instr_n   = fetch ? rom_data : instr_q;
    pc_n      = fetch ? pc + 1'b1 : pop ? stk[wp_dec] : (push || do_jump) ? target : pc;
    depth_n   = pop ? depth - 1'b1 : (push && !stack_full) ? depth + 1'b1 : depth;
    wp_n      = pop ? wp_dec : push ? wp_inc : wp;
    err_n     = stack_err || underflow || overflow;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= '0;
      instr_q   <= '0;
      depth     <= '0;
      wp        <= '0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      instr_q   <= instr_n;
      depth     <= depth_n;
      wp        <= wp_n;
      stack_err <= err_n;
    end
  end
  always_ff @(posedge clock) begin
    if (reset && push) stk[wp] <= pc;
  end
endmodule

// File: tb/tb_pc_stack_sequencer.sv
// tb_pc_stack_sequencer: scoreboard bench for pc_stack_sequencer with directed vectors
module tb_pc_stack_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic [7:0] rom_data = '0;
  logic jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic [11:0] target = '0;
  logic [11:0] pc;
  logic phase;
  logic [7:0] instr_q;
  logic [2:0] depth;
  logic stack_full, stack_empty, stack_err;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [11:0] pc;
    logic        ph;
    logic [7:0]  instr;
    logic [2:0]  depth;
    logic        err;
  } exp_t;
  exp_t q[$];
  event probe_ev;
  pc_stack_sequencer #(.ADDR_W(12), .INSTR_W(8), .STACK_DEPTH(4)) dut (
    .clock(clk), .reset(reset), .en(en), .rom_data(rom_data),
    .jump(jump), .call(call), .ret(ret), .target(target),
    .pc(pc), .phase(phase), .instr_q(instr_q), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );
  always #5 clk = ~clk;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or probe_ev);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (pc !== e.pc || phase !== e.ph || instr_q !== e.instr || depth !== e.depth ||
            stack_err !== e.err || stack_full !== (e.depth == 3'd4) || stack_empty !== (e.depth == 3'd0)) begin
          errors++;
          $display("FAIL state#%0d: got pc=%h ph=%b instr=%h depth=%0d full=%b empty=%b err=%b, want pc=%h ph=%b instr=%h depth=%0d full=%b empty=%b err=%b",
                   checks, pc, phase, instr_q, depth, stack_full, stack_empty, stack_err,
                   e.pc, e.ph, e.instr, e.depth, e.depth == 3'd4, e.depth == 3'd0, e.err);
        end
      end
    end
  end
  task automatic step(input logic e_i, input logic [7:0] rd, input logic j, input logic c, input logic r,
                      input logic [11:0] tg, input logic [11:0] epc, input logic eph,
                      input logic [7:0] ein, input logic [2:0] ed, input logic eerr);
    en = e_i; rom_data = rd; jump = j; call = c; ret = r; target = tg;
    q.push_back('{epc, eph, ein, ed, eerr});
    @(negedge clk);
  endtask
  task automatic async_reset();
    en = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    #2 reset = 1'b0;
    q.push_back('{12'h000, 1'b0, 8'h00, 3'd0, 1'b0});
    -> probe_ev;
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    @(negedge clk);
    async_reset();
    step(1, 8'hA5, 0, 0, 0, 12'h000, 12'h001, 1, 8'hA5, 0, 0);
    step(1, 8'h00, 0, 0, 0, 12'h010, 12'h001, 0, 8'hA5, 0, 0);
    step(1, 8'h00, 1, 0, 0, 12'h000, 12'h002, 1, 8'h00, 0, 0);
    step(1, 8'h00, 1, 0, 0, 12'h010, 12'h010, 0, 8'h00, 0, 0);
    step(1, 8'hC1, 0, 0, 0, 12'h000, 12'h011, 1, 8'hC1, 0, 0);
    step(1, 8'h00, 0, 1, 0, 12'h200, 12'h200, 0, 8'hC1, 1, 0);
    step(1, 8'h22, 1, 1, 1, 12'h3AB, 12'h201, 1, 8'h22, 1, 0);
    step(1, 8'h00, 0, 0, 1, 12'h000, 12'h011, 0, 8'h22, 0, 0);
    step(0, 8'hEE, 1, 1, 1, 12'h123, 12'h011, 0, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0, 0, 12'h000, 12'h012, 1, 8'h33, 0, 0);
    step(1, 8'h00, 1, 0, 0, 12'h054, 12'h054, 0, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0, 0, 12'h000, 12'h055, 1, 8'h44, 0, 0);
    step(1, 8'h00, 0, 1, 0, 12'h100, 12'h100, 0, 8'h44, 1, 0);
    step(1, 8'h55, 0, 0, 0, 12'h000, 12'h101, 1, 8'h55, 1, 0);
    step(1, 8'h00, 1, 1, 1, 12'h300, 12'h055, 0, 8'h55, 0, 0);
    step(1, 8'h66, 0, 0, 0, 12'h000, 12'h056, 1, 8'h66, 0, 0);
    step(1, 8'h00, 0, 0, 1, 12'h000, 12'h056, 0, 8'h66, 0, 1);
    step(1, 8'h77, 0, 0, 0, 12'h000, 12'h057, 1, 8'h77, 0, 1);
    step(1, 8'h00, 0, 1, 0, 12'h080, 12'h080, 0, 8'h77, 1, 1);
    step(1, 8'h88, 0, 0, 0, 12'h000, 12'h081, 1, 8'h88, 1, 1);
    step(1, 8'h00, 1, 0, 0, 12'hFFF, 12'hFFF, 0, 8'h88, 1, 1);
    step(1, 8'hA5, 0, 0, 0, 12'h000, 12'h000, 1, 8'hA5, 1, 1);
    async_reset();
    step(1, 8'h01, 0, 0, 0, 12'h000, 12'h001, 1, 8'h01, 0, 0);
    step(1, 8'h00, 0, 1, 0, 12'h0A0, 12'h0A0, 0, 8'h01, 1, 0);
    step(1, 8'h02, 0, 0, 0, 12'h000, 12'h0A1, 1, 8'h02, 1, 0);
    step(1, 8'h00, 0, 1, 0, 12'h0B0, 12'h0B0, 0, 8'h02, 2, 0);
    step(1, 8'h03, 0, 0, 0, 12'h000, 12'h0B1, 1, 8'h03, 2, 0);
    step(1, 8'h00, 0, 1, 0, 12'h0C0, 12'h0C0, 0, 8'h03, 3, 0);
    step(1, 8'h04, 0, 0, 0, 12'h000, 12'h0C1, 1, 8'h04, 3, 0);
    step(1, 8'h00, 0, 1, 0, 12'h0D0, 12'h0D0, 0, 8'h04, 4, 0);
    step(1, 8'h05, 0, 0, 0, 12'h000, 12'h0D1, 1, 8'h05, 4, 0);
`ifdef STACK_CIRCULAR_EN
    step(1, 8'h00, 0, 1, 0, 12'h0E0, 12'h0E0, 0, 8'h05, 4, 0);
    step(1, 8'h06, 0, 0, 0, 12'h000, 12'h0E1, 1, 8'h06, 4, 0);
    step(1, 8'h00, 0, 0, 1, 12'h000, 12'h0D1, 0, 8'h06, 3, 0);
    step(1, 8'h07, 0, 0, 0, 12'h000, 12'h0D2, 1, 8'h07, 3, 0);
    step(1, 8'h00, 0, 0, 1, 12'h000, 12'h0C1, 0, 8'h07, 2, 0);
    step(1, 8'h08, 0, 0, 0, 12'h000, 12'h0C2, 1, 8'h08, 2, 0);
    step(1, 8'h00, 0, 0, 1, 12'h000, 12'h0B1, 0, 8'h08, 1, 0);
    step(1, 8'h09, 0, 0, 0, 12'h000, 12'h0B2, 1, 8'h09, 1, 0);
    step(1, 8'h00, 0, 0, 1, 12'h000, 12'h0A1, 0, 8'h09, 0, 0);
    step(1, 8'h0A, 0, 0, 0, 12'h000, 12'h0A2, 1, 8'h0A, 0, 0);
    step(1, 8'h00, 0, 0, 1, 12'h000, 12'h0A2, 0, 8'h0A, 0, 1);
`else
    step(1, 8'h00, 0, 1, 0, 12'h0E0, 12'h0D1, 0, 8'h05, 4, 1);
    step(1, 8'h06, 0, 0, 0, 12'h000, 12'h0D2, 1, 8'h06, 4, 1);
    step(1, 8'h00, 0, 0, 1, 12'h000, 12'h0C1, 0, 8'h06, 3, 1);
    step(1, 8'h07, 0, 0, 0, 12'h000, 12'h0C2, 1, 8'h07, 3, 1);
    step(1, 8'h00, 0, 0, 1, 12'h000, 12'h0B1, 0, 8'h07, 2, 1);
    step(1, 8'h08, 0, 0, 0, 12'h000, 12'h0B2, 1, 8'h08, 2, 1);
    step(1, 8'h00, 0, 0, 1, 12'h000, 12'h0A1, 0, 8'h08, 1, 1);
    step(1, 8'h09, 0, 0, 0, 12'h000, 12'h0A2, 1, 8'h09, 1, 1);
    step(1, 8'h00, 0, 0, 1, 12'h000, 12'h001, 0, 8'h09, 0, 1);
    step(1, 8'h0A, 0, 0, 0, 12'h000, 12'h002, 1, 8'h0A, 0, 1);
    step(1, 8'h00, 0, 0, 1, 12'h000, 12'h002, 0, 8'h0A, 0, 1);
`endif
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
